// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN     = 1'b0;
    localparam state_t ST_MEMWAIT = 1'b1;

    localparam int MEM_TIMEOUT_DEFAULT = 15;
    localparam int WAIT_W              = 8;
    localparam int STAT_W              = 16;

    typedef logic [STAT_W-1:0] stat_t;

    // Event counters stick at all-ones instead of wrapping back to a small value.
    function automatic stat_t stat_inc(input stat_t v);
        return (v == '1) ? v : v + stat_t'(1);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use compare: the load in EX writes a register the instruction in ID reads.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       load_use
);

    // Register $zero is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, branch flush, load-use bubble.
// Event counters are built only when PIPE_STALL_STATS_EN is defined; otherwise the stat ports read 0.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rt,
    input  logic              mem_branch_taken,
    input  logic              exmem_memaccess,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_bubble,
    output logic              mem_err,
    output logic [STAT_W-1:0] stat_loaduse,
    output logic [STAT_W-1:0] stat_memwait,
    output logic [STAT_W-1:0] stat_flush
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;
    logic              lu_evt;
    logic              br_evt;
    logic              timeout;

    pipe_hazard_detect u_hazard (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use     (load_use)
    );

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        mem_stall    = 1'b0;
        lu_evt       = 1'b0;
        br_evt       = 1'b0;
        timeout      = 1'b0;
        dmem_req     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;

        if (rst) begin
            if (state == ST_MEMWAIT) begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end else begin
                dmem_req = exmem_memaccess;
                // Priority: memory stall, then taken-branch flush, then load-use bubble.
                if (exmem_memaccess && !dmem_ready) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_MEMWAIT;
                end else if (mem_branch_taken) begin
                    br_evt      = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    lu_evt     = 1'b1;
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end

        if (mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_loaduse <= '0;
            stat_memwait <= '0;
            stat_flush   <= '0;
        end else begin
            if (lu_evt)    stat_loaduse <= stat_inc(stat_loaduse);
            if (mem_stall) stat_memwait <= stat_inc(stat_memwait);
            if (br_evt)    stat_flush   <= stat_inc(stat_flush);
        end
    end
`else
    assign stat_loaduse = '0;
    assign stat_memwait = '0;
    assign stat_flush   = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (MEM_TIMEOUT=4); stat expectations follow PIPE_STALL_STATS_EN.
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    // Output bundle order: dmem_req, pc_en, ifid_en, idex_en, exmem_en,
    // ifid_flush, idex_flush, exmem_flush, memwb_bubble
    localparam logic [8:0] O_DEF   = 9'b0_1111_000_0;
    localparam logic [8:0] O_LU    = 9'b0_0011_010_0;
    localparam logic [8:0] O_BR    = 9'b0_1111_111_0;
    localparam logic [8:0] O_REQ   = 9'b1_1111_000_0;
    localparam logic [8:0] O_REQLU = 9'b1_0011_010_0;
    localparam logic [8:0] O_STALL = 9'b1_0000_000_1;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] xrt;
        logic       br;
        logic       ma;
        logic       rdy;
        logic [8:0] outs;
        logic       err;
        int         lu;
        int         mw;
        int         fl;
    } vec_t;

    typedef struct {
        logic [9:0]  outs_err;
        logic [47:0] stats;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        idex_memread, mem_branch_taken, exmem_memaccess, dmem_ready;
    logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err;
    logic [15:0] stat_loaduse, stat_memwait, stat_flush;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t table_v[14];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .idex_memread     (idex_memread),
        .idex_rt          (idex_rt),
        .mem_branch_taken (mem_branch_taken),
        .exmem_memaccess  (exmem_memaccess),
        .dmem_ready       (dmem_ready),
        .dmem_req         (dmem_req),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .memwb_bubble     (memwb_bubble),
        .mem_err          (mem_err),
        .stat_loaduse     (stat_loaduse),
        .stat_memwait     (stat_memwait),
        .stat_flush       (stat_flush)
    );

    function automatic logic [15:0] sx(input int v);
`ifdef PIPE_STALL_STATS_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic mr, input logic [4:0] xrt, input logic br,
                                input logic ma, input logic rdy, input logic [8:0] outs,
                                input logic err, input int lu, input int mw, input int fl);
        vec_t v;
        v.rst = r;  v.rs = rs;  v.rt = rt;  v.mr = mr;  v.xrt = xrt;
        v.br = br;  v.ma = ma;  v.rdy = rdy;
        v.outs = outs;  v.err = err;  v.lu = lu;  v.mw = mw;  v.fl = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle, return just after the edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        exp_t x;
        rst = v.rst;  id_rs = v.rs;  id_rt = v.rt;  idex_memread = v.mr;  idex_rt = v.xrt;
        mem_branch_taken = v.br;  exmem_memaccess = v.ma;  dmem_ready = v.rdy;
        e.outs_err = {v.outs, v.err};
        e.stats    = {sx(v.lu), sx(v.mw), sx(v.fl)};
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        check({tag, " outputs"},
              48'({dmem_req, pc_en, ifid_en, idex_en, exmem_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err}),
              48'(x.outs_err));
        check({tag, " stats"}, {stat_loaduse, stat_memwait, stat_flush}, x.stats);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                r   rs     rt     mr  xrt    br  ma  rdy  outs     err lu mw fl
        table_v[0]  = mk(0, 5'd8,  5'd0,  1, 5'd8,  1,  1,  0,  O_DEF,   0, 0, 0, 0);
        table_v[1]  = mk(0, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  O_DEF,   0, 0, 0, 0);
        table_v[2]  = mk(1, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  O_DEF,   0, 0, 0, 0);
        table_v[3]  = mk(1, 5'd8,  5'd3,  1, 5'd8,  0,  0,  0,  O_LU,    0, 0, 0, 0);
        table_v[4]  = mk(1, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  O_DEF,   0, 1, 0, 0);
        table_v[5]  = mk(1, 5'd2,  5'd17, 1, 5'd17, 0,  0,  0,  O_LU,    0, 1, 0, 0);
        table_v[6]  = mk(1, 5'd0,  5'd0,  1, 5'd0,  0,  0,  0,  O_DEF,   0, 2, 0, 0);
        table_v[7]  = mk(1, 5'd8,  5'd0,  0, 5'd8,  0,  0,  0,  O_DEF,   0, 2, 0, 0);
        table_v[8]  = mk(1, 5'd9,  5'd10, 1, 5'd8,  0,  0,  0,  O_DEF,   0, 2, 0, 0);
        table_v[9]  = mk(1, 5'd0,  5'd0,  0, 5'd0,  1,  0,  0,  O_BR,    0, 2, 0, 0);
        table_v[10] = mk(1, 5'd5,  5'd0,  1, 5'd5,  1,  0,  0,  O_BR,    0, 2, 0, 1);
        table_v[11] = mk(1, 5'd0,  5'd0,  0, 5'd0,  0,  1,  1,  O_REQ,   0, 2, 0, 2);
        table_v[12] = mk(1, 5'd0,  5'd6,  1, 5'd6,  0,  1,  1,  O_REQLU, 0, 2, 0, 2);
        table_v[13] = mk(1, 5'd0,  5'd0,  0, 5'd0,  0,  0,  0,  O_DEF,   0, 3, 0, 2);

        rst = 1'b0;  id_rs = '0;  id_rt = '0;  idex_memread = 1'b0;  idex_rt = '0;
        mem_branch_taken = 1'b0;  exmem_memaccess = 1'b0;  dmem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), table_v[i]);
        end

        // Memory wait: three stalled cycles (branch and load-use ignored), release on the fourth.
        apply("mw_run_stall", mk(1, 5'd4, 5'd0, 1, 5'd4, 1, 1, 0, O_STALL, 0, 3, 0, 2));
        apply("mw_wait1",     mk(1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, O_STALL, 0, 3, 1, 2));
        apply("mw_wait2",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 0, 3, 2, 2));
        apply("mw_release",   mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, O_REQ,   0, 3, 3, 2));
        apply("mw_after",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_DEF,   0, 3, 3, 2));

        // Timeout with MEM_TIMEOUT=4: fourth MEMWAIT cycle releases, mem_err sticks.
        apply("to_run_stall", mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 0, 3, 3, 2));
        apply("to_wait0",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 0, 3, 4, 2));
        apply("to_wait1",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 0, 3, 5, 2));
        apply("to_wait2",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 0, 3, 6, 2));
        apply("to_release",   mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_REQ,   0, 3, 7, 2));
        apply("to_err_set",   mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_DEF,   1, 3, 7, 2));
        apply("to_err_hold",  mk(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, O_BR,    1, 3, 7, 2));

        // Reset in the middle of MEMWAIT aborts the wait and clears everything.
        apply("rst_run_stall", mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 1, 3, 7, 3));
        apply("rst_wait0",     mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_STALL, 1, 3, 8, 3));
        apply("rst_assert",    mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_DEF,   1, 3, 9, 3));
        apply("rst_in_run",    mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_DEF,   0, 0, 0, 0));
        apply("rst_ready_run", mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, O_REQ,   0, 0, 0, 0));
        apply("rst_loaduse",   mk(1, 5'd0, 5'd12, 1, 5'd12, 0, 0, 0, O_LU,  0, 0, 0, 0));
        apply("rst_lu_count",  mk(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_DEF,   0, 1, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
